// File: rtl/shiftreg_arb_pkg.sv
// Shared types and helpers for the shift-register arbiter/controller.
package shiftreg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ERR   = 2'd2
  } arb_state_t;

  // Index width that stays at least 1 bit for degenerate counts.
  function automatic int unsigned tag_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned ID_W = tag_w(4);

endpackage

// File: rtl/shiftreg_arb_ctrl_if.sv
// Handshake bundle between the arbiter and the shared 3-stage shift-register pipeline.
interface shiftreg_arb_ctrl_if #(
  parameter int unsigned DATA_BIT_WIDTH = 8
) ();

  logic                      sr_enable_o;
  logic [DATA_BIT_WIDTH-1:0] sr_d_o;
  logic                      sr_enable_ack_i;
  logic                      sr_valid_i;
  logic [DATA_BIT_WIDTH-1:0] sr_q_i;

  modport master (
    output sr_enable_o, sr_d_o,
    input  sr_enable_ack_i, sr_valid_i, sr_q_i
  );

  modport slave (
    input  sr_enable_o, sr_d_o,
    output sr_enable_ack_i, sr_valid_i, sr_q_i
  );

endinterface

// File: rtl/shiftreg_arb_tagfifo.sv
// Requester-ID FIFO tracking words issued to the pipeline but not yet returned.
module shiftreg_arb_tagfifo
  import shiftreg_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned W     = ID_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [W-1:0]               id_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned PW = tag_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap explicitly since DEPTH need not be a power of two.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (do_pop)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      if (do_push) mem_q[wr_q] <= id_i;
    end
  end

endmodule

// File: rtl/shiftreg_arb_ctrl.sv
// Arbitrates requesters onto a shared shift-register pipeline and routes tagged responses back.
// Define SHIFTREG_ARB_STRICT_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module shiftreg_arb_ctrl
  import shiftreg_arb_pkg::*;
#(
  parameter int unsigned DATA_BIT_WIDTH = 8,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned MAX_INFLIGHT   = 3,
  parameter int unsigned ACK_TIMEOUT    = 16
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req_i,
  input  logic [NUM_REQ*DATA_BIT_WIDTH-1:0]   data_i,
  output logic [NUM_REQ-1:0]                  gnt_o,
  shiftreg_arb_ctrl_if.master                 sr,
  output logic                                rsp_valid_o,
  output logic [tag_w(NUM_REQ)-1:0]           rsp_id_o,
  output logic [DATA_BIT_WIDTH-1:0]           rsp_data_o,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight_o,
  output logic                                err_o
);

  localparam int unsigned IDW = tag_w(NUM_REQ);
  localparam int unsigned CW  = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned TW  = $clog2(ACK_TIMEOUT + 1);

  arb_state_t                state_q, state_d;
  logic [IDW-1:0]            id_q, id_d;
  logic                      sr_enable_q, sr_enable_d;
  logic [DATA_BIT_WIDTH-1:0] sr_d_q, sr_d_d;
  logic [NUM_REQ-1:0]        gnt_q, gnt_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      err_q, err_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]            rsp_id_q, rsp_id_d;
  logic [DATA_BIT_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]            win;
  logic                      push, pop;
  logic [IDW-1:0]            fifo_head;
  logic [CW-1:0]             fifo_count;
  logic                      fifo_empty, fifo_full;
`ifndef SHIFTREG_ARB_STRICT_PRIO_EN
  logic [IDW-1:0]            rr_q, rr_d;
`endif

`ifdef SHIFTREG_ARB_STRICT_PRIO_EN
  function automatic logic [IDW-1:0] pick(input logic [NUM_REQ-1:0] req);
    logic [IDW-1:0] sel;
    logic           found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        sel   = IDW'(i);
        found = 1'b1;
      end
    end
    return sel;
  endfunction
`else
  function automatic logic [IDW-1:0] pick(input logic [NUM_REQ-1:0] req,
                                          input logic [IDW-1:0]     ptr);
    logic [IDW-1:0] sel;
    logic           found;
    int unsigned    idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        sel   = IDW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    sr_enable_d = sr_enable_q;
    sr_d_d      = sr_d_q;
    gnt_d       = '0;
    timer_d     = timer_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    push        = 1'b0;
    pop         = 1'b0;
`ifdef SHIFTREG_ARB_STRICT_PRIO_EN
    win         = pick(req_i);
`else
    rr_d        = rr_q;
    win         = pick(req_i, rr_q);
`endif

    case (state_q)
      // Skipping the grant cycle keeps the just-granted requester's held req from re-winning.
      IDLE: begin
        if (|req_i && !fifo_full && (gnt_q == '0)) begin
          id_d        = win;
          sr_d_d      = data_i[32'(win)*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
          sr_enable_d = 1'b1;
          timer_d     = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (sr.sr_enable_ack_i) begin
          gnt_d       = NUM_REQ'(1) << id_q;
          sr_enable_d = 1'b0;
          push        = 1'b1;
          timer_d     = '0;
          state_d     = IDLE;
`ifndef SHIFTREG_ARB_STRICT_PRIO_EN
          rr_d        = IDW'((32'(id_q) + 1) % NUM_REQ);
`endif
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          sr_enable_d = 1'b0;
          err_d       = 1'b1;
          state_d     = ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ERR:     ;
      default: state_d = IDLE;
    endcase

    if (sr.sr_valid_i) begin
      if (!fifo_empty) begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = fifo_head;
        rsp_data_d  = sr.sr_q_i;
        pop         = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      id_q        <= '0;
      sr_enable_q <= 1'b0;
      sr_d_q      <= '0;
      gnt_q       <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
`ifndef SHIFTREG_ARB_STRICT_PRIO_EN
      rr_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      sr_enable_q <= sr_enable_d;
      sr_d_q      <= sr_d_d;
      gnt_q       <= gnt_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
`ifndef SHIFTREG_ARB_STRICT_PRIO_EN
      rr_q        <= rr_d;
`endif
    end
  end

  shiftreg_arb_tagfifo #(
    .DEPTH (MAX_INFLIGHT),
    .W     (IDW)
  ) u_tagfifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .id_i    (id_q),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign gnt_o          = gnt_q;
  assign sr.sr_enable_o = sr_enable_q;
  assign sr.sr_d_o      = sr_d_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_id_o       = rsp_id_q;
  assign rsp_data_o     = rsp_data_q;
  assign inflight_o     = fifo_count;
  assign err_o          = err_q;

endmodule

// File: tb/tb_shiftreg_arb_ctrl.sv
// Directed self-checking bench for shiftreg_arb_ctrl.
module tb_shiftreg_arb_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NR-1:0]    req_i;
  logic [NR*DW-1:0] data_i;
  logic [NR-1:0]    gnt_o;
  logic             rsp_valid_o;
  logic [1:0]       rsp_id_o;
  logic [DW-1:0]    rsp_data_o;
  logic [1:0]       inflight_o;
  logic             err_o;

  int n_checks = 0;
  int n_fail   = 0;

  shiftreg_arb_ctrl_if #(.DATA_BIT_WIDTH(DW)) sr_if ();

  shiftreg_arb_ctrl #(
    .DATA_BIT_WIDTH (DW),
    .NUM_REQ        (NR),
    .MAX_INFLIGHT   (3),
    .ACK_TIMEOUT    (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_i       (req_i),
    .data_i      (data_i),
    .gnt_o       (gnt_o),
    .sr          (sr_if),
    .rsp_valid_o (rsp_valid_o),
    .rsp_id_o    (rsp_id_o),
    .rsp_data_o  (rsp_data_o),
    .inflight_o  (inflight_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int gnt_id(input logic [NR-1:0] g);
    for (int i = 0; i < NR; i++) if (g[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] all_outs();
    return {5'd0, gnt_o, sr_if.sr_enable_o, sr_if.sr_d_o, rsp_valid_o, rsp_id_o,
            rsp_data_o, inflight_o, err_o};
  endfunction

  task automatic do_reset();
    reset_n                = 1'b0;
    req_i                  = '0;
    data_i                 = '0;
    sr_if.sr_enable_ack_i  = 1'b0;
    sr_if.sr_valid_i       = 1'b0;
    sr_if.sr_q_i           = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp2 [5];
    int got2 [5];
    int got_n, n_g, n_en, seen;
`ifdef SHIFTREG_ARB_STRICT_PRIO_EN
    exp2 = '{0, 0, 0, 0, 0};
`else
    exp2 = '{0, 1, 2, 3, 0};
`endif

    // Test 1: single request, full round trip
    do_reset();
    check("reset_outputs", all_outs(), 32'h0);
    data_i[7:0] = 8'hAA;
    req_i       = 4'b0001;
    tick();
    check("t1_enable", {31'd0, sr_if.sr_enable_o}, 1);
    check("t1_sr_d", {24'd0, sr_if.sr_d_o}, 32'hAA);
    check("t1_no_gnt_yet", {28'd0, gnt_o}, 0);
    sr_if.sr_enable_ack_i = 1'b1;
    data_i[7:0]           = 8'h55;
    tick();
    check("t1_gnt", {28'd0, gnt_o}, 32'b0001);
    check("t1_enable_drop", {31'd0, sr_if.sr_enable_o}, 0);
    check("t1_inflight1", {30'd0, inflight_o}, 1);
    sr_if.sr_enable_ack_i = 1'b0;
    req_i                 = '0;
    tick();
    check("t1_gnt_pulse", {28'd0, gnt_o}, 0);
    tick();
    sr_if.sr_valid_i = 1'b1;
    sr_if.sr_q_i     = 8'hAA;
    tick();
    sr_if.sr_valid_i = 1'b0;
    check("t1_rsp_valid", {31'd0, rsp_valid_o}, 1);
    check("t1_rsp_id", {30'd0, rsp_id_o}, 0);
    check("t1_rsp_data", {24'd0, rsp_data_o}, 32'hAA);
    check("t1_inflight0", {30'd0, inflight_o}, 0);
    tick();
    check("t1_rsp_pulse", {31'd0, rsp_valid_o}, 0);
    check("t1_no_err", {31'd0, err_o}, 0);

    // Test 2: all requesters held, immediate acks and returns
    do_reset();
    data_i = {8'h43, 8'h32, 8'h21, 8'h10};
    req_i  = 4'b1111;
    got_n  = 0;
    for (int c = 0; c < 60 && got_n < 5; c++) begin
      tick();
      if (gnt_o != '0) begin
        got2[got_n] = gnt_id(gnt_o);
        got_n++;
      end
      sr_if.sr_enable_ack_i = sr_if.sr_enable_o;
      sr_if.sr_valid_i      = (gnt_o != '0);
    end
    check("t2_grant_count", got_n, 5);
    for (int k = 0; k < 5; k++) check($sformatf("t2_grant%0d", k), got2[k], exp2[k]);
    check("t2_no_err", {31'd0, err_o}, 0);

    // Test 3: inflight limit blocks a 4th issue until a response drains one
    do_reset();
    data_i[7:0] = 8'h5A;
    req_i       = 4'b0001;
    n_g         = 0;
    n_en        = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (gnt_o != '0) n_g++;
      if (sr_if.sr_enable_o) n_en++;
      sr_if.sr_enable_ack_i = sr_if.sr_enable_o;
    end
    check("t3_grants", n_g, 3);
    check("t3_enables", n_en, 3);
    check("t3_inflight3", {30'd0, inflight_o}, 3);
    sr_if.sr_enable_ack_i = 1'b0;
    sr_if.sr_valid_i      = 1'b1;
    sr_if.sr_q_i          = 8'h5A;
    tick();
    sr_if.sr_valid_i = 1'b0;
    check("t3_rsp_valid", {31'd0, rsp_valid_o}, 1);
    check("t3_rsp_id", {30'd0, rsp_id_o}, 0);
    check("t3_rsp_data", {24'd0, rsp_data_o}, 32'h5A);
    check("t3_inflight2", {30'd0, inflight_o}, 2);
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      tick();
      if (sr_if.sr_enable_o) seen = 1;
    end
    check("t3_fourth_issue", seen, 1);

    // Test 4: ack never arrives
    do_reset();
    req_i = 4'b0010;
    n_en  = 0;
    for (int c = 0; c < 40 && !err_o; c++) begin
      tick();
      if (sr_if.sr_enable_o) n_en++;
    end
    check("t4_enable_cycles", n_en, 16);
    check("t4_err", {31'd0, err_o}, 1);
    check("t4_enable_off", {31'd0, sr_if.sr_enable_o}, 0);
    n_g = 0;
    for (int c = 0; c < 10; c++) begin
      sr_if.sr_enable_ack_i = 1'b1;
      tick();
      if (gnt_o != '0 || sr_if.sr_enable_o) n_g++;
    end
    sr_if.sr_enable_ack_i = 1'b0;
    check("t4_no_more_activity", n_g, 0);
    check("t4_err_sticky", {31'd0, err_o}, 1);

    // Test 5: spurious valid with nothing outstanding
    do_reset();
    sr_if.sr_valid_i = 1'b1;
    sr_if.sr_q_i     = 8'h77;
    tick();
    sr_if.sr_valid_i = 1'b0;
    check("t5_err", {31'd0, err_o}, 1);
    check("t5_no_rsp", {31'd0, rsp_valid_o}, 0);
    tick();
    check("t5_no_rsp_later", {31'd0, rsp_valid_o}, 0);
    check("t5_inflight", {30'd0, inflight_o}, 0);

    // Test 6: asynchronous reset in the middle of an issue
    do_reset();
    data_i[7:0] = 8'h3C;
    req_i       = 4'b0001;
    seen        = 0;
    for (int c = 0; c < 30 && seen == 0; c++) begin
      tick();
      if (inflight_o == 2'd2 && sr_if.sr_enable_o) seen = 1;
      else sr_if.sr_enable_ack_i = sr_if.sr_enable_o;
    end
    check("t6_mid_issue", seen, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_clear", all_outs(), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    check("t6_enable_after", {31'd0, sr_if.sr_enable_o}, 1);
    sr_if.sr_enable_ack_i = 1'b1;
    tick();
    sr_if.sr_enable_ack_i = 1'b0;
    req_i                 = '0;
    check("t6_gnt_after", {28'd0, gnt_o}, 32'b0001);
    check("t6_inflight_after", {30'd0, inflight_o}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
